// File: rtl/tl_left_ctrl.sv
// Two-street traffic light controller with protected left-turn phases.
// Define TL_LEFT_SKIP_EN to skip a street's left phase when no left-turn request is pending.
module tl_left_ctrl #(
  parameter int unsigned GREEN_T  = 8,
  parameter int unsigned YELLOW_T = 2,
  parameter int unsigned LEFT_T   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ta,
  input  logic       tb,
  input  logic       lreq_a,
  input  logic       lreq_b,
  output logic [1:0] light_a,
  output logic [1:0] light_b,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S0 = 3'd0, S1 = 3'd1, S2 = 3'd2, S3 = 3'd3,
    S4 = 3'd4, S5 = 3'd5, S6 = 3'd6, S7 = 3'd7
  } phase_e;

  localparam logic [1:0] LAMP_G = 2'b00;
  localparam logic [1:0] LAMP_Y = 2'b01;
  localparam logic [1:0] LAMP_R = 2'b10;
  localparam logic [1:0] LAMP_L = 2'b11;

  localparam logic [3:0] GREEN_TERM  = 4'(GREEN_T - 1);
  localparam logic [3:0] YELLOW_TERM = 4'(YELLOW_T - 1);
  localparam logic [3:0] LEFT_TERM   = 4'(LEFT_T - 1);

  phase_e     state_q, state_d;
  logic [3:0] timer_q, timer_d;
  logic       pend_a_q, pend_a_d;
  logic       pend_b_q, pend_b_d;
  logic [3:0] term;
  logic       at_term;
  logic       clear_a, clear_b;

  always_comb begin
    term = YELLOW_TERM;
    unique case (state_q)
      S0, S4:  term = GREEN_TERM;
      S2, S6:  term = LEFT_TERM;
      default: term = YELLOW_TERM;
    endcase
  end

  assign at_term = (timer_q == term);

  always_comb begin
    state_d = state_q;
    if (at_term) begin
      unique case (state_q)
        S0: if (!ta) state_d = S1;
`ifdef TL_LEFT_SKIP_EN
        S1: state_d = pend_a_q ? S2 : S4;
`else
        S1: state_d = S2;
`endif
        S2: state_d = S3;
        S3: state_d = S4;
        S4: if (!tb) state_d = S5;
`ifdef TL_LEFT_SKIP_EN
        S5: state_d = pend_b_q ? S6 : S0;
`else
        S5: state_d = S6;
`endif
        S6: state_d = S7;
        S7: state_d = S0;
        default: state_d = S0;
      endcase
    end
  end

  // A request is consumed both on the entry edge and throughout the left/left-yellow pair.
  assign clear_a = (state_q inside {S2, S3}) || (state_d inside {S2, S3});
  assign clear_b = (state_q inside {S6, S7}) || (state_d inside {S6, S7});

  always_comb begin
    pend_a_d = (pend_a_q | lreq_a) & ~clear_a;
    pend_b_d = (pend_b_q | lreq_b) & ~clear_b;
    if (state_d != state_q) begin
      timer_d = '0;
    end else if (at_term) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S0;
      timer_q  <= '0;
      pend_a_q <= 1'b0;
      pend_b_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      pend_a_q <= pend_a_d;
      pend_b_q <= pend_b_d;
    end
  end

  always_comb begin
    light_a = LAMP_R;
    light_b = LAMP_R;
    unique case (state_q)
      S0: begin light_a = LAMP_G; light_b = LAMP_R; end
      S1: begin light_a = LAMP_Y; light_b = LAMP_R; end
      S2: begin light_a = LAMP_L; light_b = LAMP_R; end
      S3: begin light_a = LAMP_Y; light_b = LAMP_R; end
      S4: begin light_a = LAMP_R; light_b = LAMP_G; end
      S5: begin light_a = LAMP_R; light_b = LAMP_Y; end
      S6: begin light_a = LAMP_R; light_b = LAMP_L; end
      S7: begin light_a = LAMP_R; light_b = LAMP_Y; end
      default: begin light_a = LAMP_R; light_b = LAMP_R; end
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_tl_left_ctrl.sv
// Scoreboard bench for tl_left_ctrl: a phase/duration reference model queues expected
// outputs per clock edge or reset assertion; a monitor pops and compares them.
module tb_tl_left_ctrl;

  localparam int unsigned GT = 8;
  localparam int unsigned YT = 2;
  localparam int unsigned LT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ta = 1'b0, tb = 1'b0, lreq_a = 1'b0, lreq_b = 1'b0;
  logic [1:0] light_a, light_b;
  logic [2:0] state;

  tl_left_ctrl #(.GREEN_T(GT), .YELLOW_T(YT), .LEFT_T(LT)) dut (
    .clk(clk), .reset(reset), .ta(ta), .tb(tb), .lreq_a(lreq_a), .lreq_b(lreq_b),
    .light_a(light_a), .light_b(light_b), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic [1:0] a;
    logic [1:0] b;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Lamp codes per phase: 0 green, 1 yellow, 2 red, 3 left arrow.
  int unsigned lamp_a_tab[8] = '{0, 1, 3, 1, 2, 2, 2, 2};
  int unsigned lamp_b_tab[8] = '{2, 2, 2, 2, 0, 1, 3, 1};

  // Reference model: current phase, completed cycles in it, pending left requests.
  int unsigned m_p = 0;
  int unsigned m_age = 0;
  bit          m_pa = 0, m_pb = 0;

  function automatic int unsigned dur(input int unsigned p);
    if (p == 0 || p == 4) return GT;
    if (p == 2 || p == 6) return LT;
    return YT;
  endfunction

  function automatic int unsigned succ(input int unsigned p, input bit pa, input bit pb);
`ifdef TL_LEFT_SKIP_EN
    if (p == 1) return pa ? 2 : 4;
    if (p == 5) return pb ? 6 : 0;
`endif
    return (p + 1) % 8;
  endfunction

  task automatic model_reset();
    m_p = 0; m_age = 0; m_pa = 0; m_pb = 0;
  endtask

  task automatic model_edge(input bit a_s, input bit b_s, input bit la, input bit lb);
    int unsigned d, np;
    bit go, ca, cb;
    d  = dur(m_p);
    go = (m_age + 1 >= d) && !((m_p == 0 && a_s) || (m_p == 4 && b_s));
    np = go ? succ(m_p, m_pa, m_pb) : m_p;
    ca = (m_p == 2 || m_p == 3 || np == 2 || np == 3);
    cb = (m_p == 6 || m_p == 7 || np == 6 || np == 7);
    m_pa = (m_pa || la) && !ca;
    m_pb = (m_pb || lb) && !cb;
    if (np != m_p) m_age = 0;
    else if (m_age + 1 < d) m_age = m_age + 1;
    m_p = np;
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    e.st  = 3'(m_p);
    e.a   = 2'(lamp_a_tab[m_p]);
    e.b   = 2'(lamp_b_tab[m_p]);
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  // One clock period: inputs change on the falling edge, expectation for the next rising edge.
  task automatic cycle(input bit a_s, input bit b_s, input bit la, input bit lb,
                       input bit rst_pulse, input string tag);
    @(negedge clk);
    ta = a_s; tb = b_s; lreq_a = la; lreq_b = lb;
    if (rst_pulse && reset) begin
      model_reset();
      push_exp("async_reset");
      push_exp("reset_edge");
      reset = 1'b0;
    end else begin
      reset = 1'b1;
      model_edge(a_s, b_s, la, lb);
      push_exp(tag);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or negedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (state !== e.st || light_a !== e.a || light_b !== e.b) begin
          n_err++;
          $display("FAIL %s @%0t: got state=%0d light_a=%b light_b=%b, expected state=%0d light_a=%b light_b=%b",
                   e.tag, $time, state, light_a, light_b, e.st, e.a, e.b);
        end
      end
    end
  end

  initial begin : stimulus
    bit prev_rst;
    bit r;
    repeat (2) @(negedge clk);
    model_reset();
    push_exp("reset_state");

    for (int i = 0; i < 70; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "free_run");

    for (int i = 0; i < 40 && m_p != 0; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "to_s0");
    for (int i = 0; i < 25; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ta_hold");
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "ta_drop");

    for (int i = 0; i < 50 && !(m_p == 5 && m_age == 1); i++)
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "to_s5");
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "s5_reset");
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "after_reset");

    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "lreq_hold");

    prev_rst = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      r = (!prev_rst) && ($urandom_range(0, 99) == 0);
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, r, "random");
      prev_rst = r;
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tl_left_ctrl.md
TL_LEFT_CTRL -- requirements
Module: tl_left_ctrl

Interface
REQ-001 The block SHALL have the parameter GREEN_T, default 8, which sets the minimum green length in cycles (legal range 1..16).
REQ-002 The block SHALL have the parameter YELLOW_T, default 2, which sets the yellow length in cycles (legal range 1..16).
REQ-003 The block SHALL have the parameter LEFT_T, default 4, which sets the left-arrow length in cycles (legal range 1..16).
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have the port ta, input, 1 bit: street A through-traffic sensor.
REQ-007 The block SHALL have the port tb, input, 1 bit: street B through-traffic sensor.
REQ-008 The block SHALL have the port lreq_a, input, 1 bit: street A left-turn request pulse or level.
REQ-009 The block SHALL have the port lreq_b, input, 1 bit: street B left-turn request pulse or level.
REQ-010 The block SHALL have the port light_a, output, 2 bits: street A lamp code (00 green, 01 yellow, 10 red, 11 left arrow).
REQ-011 The block SHALL have the port light_b, output, 2 bits: street B lamp code, using the same encoding as light_a.
REQ-012 The block SHALL have the port state, output, 3 bits: current phase, S0..S7.

Function
REQ-013 The phase SHALL be held in a 3-bit register: S0 A-green, S1 A-yellow, S2 A-left, S3 A-left-yellow, S4 B-green, S5 B-yellow, S6 B-left, S7 B-left-yellow.
REQ-014 The lamp decode SHALL be purely combinational from state:
- S0: A=G, B=R
- S1: A=Y, B=R
- S2: A=L, B=R
- S3: A=Y, B=R
- S4: A=R, B=G
- S5: A=R, B=Y
- S6: A=R, B=L
- S7: A=R, B=Y
REQ-015 A 4-bit timer SHALL count cycles in the current phase. It clears to 0 on every phase change, increments otherwise, and saturates at the phase terminal value.
REQ-016 The terminal values SHALL be GREEN_T-1 for S0/S4, YELLOW_T-1 for S1/S3/S5/S7, and LEFT_T-1 for S2/S6.
REQ-017 The green phases SHALL exit as follows:
- S0 exits to S1 when the timer is at terminal and ta==0; otherwise it holds.
- S4 exits to S5 when the timer is at terminal and tb==0; otherwise it holds.
REQ-018 All other phases SHALL advance unconditionally when the timer is at terminal:
- S1 to S2 (or S4, see Configuration)
- S2 to S3
- S3 to S4
- S5 to S6 (or S0)
- S6 to S7
- S7 to S0
REQ-019 Sticky flags pend_a and pend_b SHALL capture lreq_a and lreq_b on any cycle, as pend_x_next = (pend_x | lreq_x) & ~clear_x.
REQ-020 clear_a SHALL be asserted on the cycle the phase enters S2 or S3 and while the phase is in S2 or S3. A request in those cycles is consumed, not held over. clear_b SHALL behave the same for S6 and S7.
REQ-021 When the timer is at terminal and the exit condition is true in the same cycle, the transition SHALL take precedence over the saturate/hold behaviour.
REQ-022 A change of ta or tb SHALL only affect the transition evaluated on the next rising edge; the latency from sensor to state change SHALL be one cycle.

Reset
REQ-023 While reset==0, the block SHALL asynchronously force state=S0, timer=0, pend_a=0 and pend_b=0, giving light_a=00 and light_b=10.
REQ-024 An assertion of reset in the middle of a phase SHALL abort that phase immediately, with no completion of yellow.
REQ-025 On release, the first rising edge SHALL start the S0 count from timer 0.

Configuration
REQ-026 With TL_LEFT_SKIP_EN defined, S1 SHALL go to S2 only if pend_a==1 and otherwise go to S4, and S5 SHALL go to S6 only if pend_b==1 and otherwise go to S0.
REQ-027 Without TL_LEFT_SKIP_EN, the left phases SHALL always be visited; pend_a and pend_b are still maintained but do not affect transitions.

Verification
REQ-028 With default parameters, no macro, and ta=tb=0 after reset release: S0 SHALL last 8 cycles, then S1 2, S2 4, S3 2, S4 8, S5 2, S6 4, S7 2, then back to S0 (a 32-cycle period).
REQ-029 With ta=1 held: the phase SHALL stay in S0 indefinitely with the timer saturated at 7; dropping ta SHALL give S1 on the next edge.
REQ-030 With TL_LEFT_SKIP_EN, no lreq, and ta=tb=0: the sequence SHALL be S0(8), S1(2), S4(8), S5(2), S0, i.e. a 20-cycle period with light_a never equal to 11.
REQ-031 With TL_LEFT_SKIP_EN and a 1-cycle lreq_a pulse during S4: on the next S1 exit the phase SHALL go to S2, pend_a SHALL clear on entry, and the following A cycle SHALL skip S2.
REQ-032 With lreq_a held high during S2: pend_a SHALL read 0 after S3 exits, so no repeated left phase occurs.
REQ-033 Asserting reset for 1 cycle while in S5 with timer=1: the block SHALL give state=S0, light_a=00 and light_b=10 immediately, without waiting for a clock edge.
